fir_tap_load_ctrl: RTL and testbench
====================================

// Module: fir_tap_load_ctrl
// PURPOSE
//  Sequencer in front of configurable_fir: owns the FIR's enable, programs its taps
//  from a double-buffered host shadow bank, and gates the sample stream into it.
//  Host writes the inactive bank and pulses commit. The block drains the in-flight
//  sample, restarts the FIR, streams G_NUM_TAPS taps and reopens the sample path.
// PARAMETERS
//  G_NUM_TAPS       16  taps per bank; must match the FIR instance
//  G_TAP_WIDTH      16  tap word width
//  G_DATA_WIDTH     16  sample width (pass-through)
//  G_OFF_CYCLES      2  cycles fir_enable is held low before loading (>=1)
// PORTS
//  clk               in   1        clock
//  reset             in   1        synchronous, active-high
//  cfg_wr_addr       in   $clog2(G_NUM_TAPS)  tap index to write in the inactive bank
//  cfg_wr_data       in   G_TAP_WIDTH  tap value
//  cfg_wr_valid      in   1        write strobe; always accepted
//  cfg_commit        in   1        1-cycle pulse: swap banks and reload the FIR
//  busy              out  1        high in every state except RUN
//  active_bank       out  1        bank currently loaded in the FIR
//  reload_count      out  8        completed reloads, wraps at 255->0
//  fir_enable        out  1        to FIR enable
//  fir_tap_din       out  G_TAP_WIDTH  tap stream to FIR
//  fir_tap_din_valid out  1        tap valid
//  fir_tap_din_ready in   1        FIR tap ready
//  fir_tap_din_done  in   1        FIR tap programming complete
//  s_din/_valid/_ready  in/in/out  G_DATA_WIDTH/1/1  upstream samples
//  m_din/_valid/_ready  out/out/in G_DATA_WIDTH/1/1  samples to FIR din
//  fir_dout_valid, fir_dout_ready  in  1  observed FIR output handshake (drain tracking)
// BEHAVIOUR
//  Reset: state IDLE; fir_enable=0, fir_tap_din_valid=0, fir_tap_din=0, busy=1, active_bank=0,
//   reload_count=0, s_din_ready=0, m_din_valid=0, pending=0, outstanding=0; bank contents not reset.
//  Reset mid-load aborts at once; the FIR is left disabled.
//  Data path combinational in RUN only: m_din=s_din, m_din_valid=s_din_valid,
//   s_din_ready=m_din_ready. Otherwise m_din_valid=0 and s_din_ready=0.
//  outstanding: +1 on m_din handshake, -1 on fir_dout_valid&fir_dout_ready.
//   Both in the same cycle -> unchanged. Width 2 bits, saturating.
//  cfg writes target bank ~active_bank at every state, including during a load.
//  FSM:
//   IDLE  : wait for cfg_commit -> DRAIN.
//   RUN   : commit or pending -> DRAIN on the next cycle; the data path closes immediately.
//   DRAIN : wait for outstanding==0 -> OFF.
//   OFF   : fir_enable=0 for G_OFF_CYCLES cycles; at entry, flip active_bank -> LOAD.
//   LOAD  : fir_enable=1; drive shadow[active_bank][idx] with valid=1.
//           idx advances on a valid&ready handshake. After idx G_NUM_TAPS-1 is accepted:
//           valid=0 the next cycle -> WAIT.
//   WAIT  : fir_tap_din_done==1 -> RUN; reload_count+1; pending cleared.
//  fir_tap_din_done is ignored outside WAIT.
//  commit outside IDLE/RUN sets pending (multiple pulses collapse to one).
//   On RUN entry with pending=1, stay in RUN 1 cycle, then reload again.
//  Tap words stay stable while valid=1 and ready=0.
//  Throughput: one tap per cycle when ready is held high. Reload latency from commit
//   (idle, ready=1): 1+G_OFF_CYCLES+G_NUM_TAPS+1+done delay.
// CONFIGURATION
//  FIR_TAP_LOAD_CHECKSUM_EN defined: adds output tap_checksum [G_TAP_WIDTH+$clog2(G_NUM_TAPS)-1:0].
//   Unsigned sum of taps accepted in the last completed load; updated on WAIT->RUN;
//   running sum cleared on OFF entry; reset to 0.
//  Undefined: the port and its logic are absent.
// TESTING
//  1. After reset, write bank1 taps k=0..15 as value k+1; pulse commit; hold fir_tap_din_ready=1.
//     -> 16 taps 1..16 in order on consecutive cycles; active_bank=1; reload_count=1;
//     busy falls; checksum=136 when the macro is on.
//  2. In RUN, hold one sample in flight (no fir_dout yet); pulse commit.
//     -> s_din_ready=0 next cycle; fir_enable stays 1 until the dout handshake; then 2 cycles low.
//  3. Toggle fir_tap_din_ready 1,0,0,1 during LOAD -> no tap is skipped or repeated;
//     fir_tap_din is stable while stalled.
//  4. Pulse commit 3 times during LOAD -> exactly one extra reload; reload_count rises by 2 in total.
//  5. Assert reset while idx=7 in LOAD -> next cycle IDLE with all outputs at reset values;
//     a new commit then loads all 16 taps from idx 0.
//  6. Write bank0 addr 3 = 0x7FFF during a bank1 load
//     -> the current load is unchanged; the next reload sends 0x7FFF at idx 3.

Source files
------------

// File: rtl/fir_tap_load_ctrl.sv
// Tap-load sequencer for configurable_fir: double-buffered tap banks, drain/off/load/wait
// reload FSM and sample gating. Optional FIR_TAP_LOAD_CHECKSUM_EN adds a tap_checksum port.
module fir_tap_load_ctrl #(
  parameter int unsigned G_NUM_TAPS   = 16,
  parameter int unsigned G_TAP_WIDTH  = 16,
  parameter int unsigned G_DATA_WIDTH = 16,
  parameter int unsigned G_OFF_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(G_NUM_TAPS)-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]        cfg_wr_data,
  input  logic                          cfg_wr_valid,
  input  logic                          cfg_commit,
  output logic                          busy,
  output logic                          active_bank,
  output logic [7:0]                    reload_count,
  output logic                          fir_enable,
  output logic [G_TAP_WIDTH-1:0]        fir_tap_din,
  output logic                          fir_tap_din_valid,
  input  logic                          fir_tap_din_ready,
  input  logic                          fir_tap_din_done,
  input  logic [G_DATA_WIDTH-1:0]       s_din,
  input  logic                          s_din_valid,
  output logic                          s_din_ready,
  output logic [G_DATA_WIDTH-1:0]       m_din,
  output logic                          m_din_valid,
  input  logic                          m_din_ready,
  input  logic                          fir_dout_valid,
  input  logic                          fir_dout_ready
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
  ,
  output logic [G_TAP_WIDTH+$clog2(G_NUM_TAPS)-1:0] tap_checksum
`endif
);

  localparam int unsigned IdxW = $clog2(G_NUM_TAPS);
  localparam int unsigned OffW = $clog2(G_OFF_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StOff, StLoad, StWait} state_e;

  state_e            state_q, state_d;
  logic              active_q, active_d;
  logic              fir_en_q, fir_en_d;
  logic [7:0]        reload_q, reload_d;
  logic              pending_q, pending_d;
  logic              rerun_q, rerun_d;
  logic [1:0]        outst_q, outst_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [OffW-1:0]   off_q, off_d;
  logic [G_TAP_WIDTH-1:0] bank_q [2][G_NUM_TAPS];

  logic path_open, m_fire, d_fire, tap_fire;

  // Path closes in the commit cycle itself and during the one RUN cycle before a queued reload.
  assign path_open   = (state_q == StRun) && !cfg_commit && !rerun_q;
  assign m_din       = s_din;
  assign m_din_valid = path_open & s_din_valid;
  assign s_din_ready = path_open & m_din_ready;

  assign fir_tap_din_valid = (state_q == StLoad);
  assign fir_tap_din       = fir_tap_din_valid ? bank_q[active_q][idx_q] : '0;
  assign busy              = (state_q != StRun);
  assign active_bank       = active_q;
  assign reload_count      = reload_q;
  assign fir_enable        = fir_en_q;

  assign m_fire   = m_din_valid & m_din_ready;
  assign d_fire   = fir_dout_valid & fir_dout_ready;
  assign tap_fire = fir_tap_din_valid & fir_tap_din_ready;

`ifdef FIR_TAP_LOAD_CHECKSUM_EN
  localparam int unsigned SumW = G_TAP_WIDTH + IdxW;
  logic [SumW-1:0] sum_q, sum_d, chk_q, chk_d;
  assign tap_checksum = chk_q;
`endif

  // Host always writes the bank not currently owned by the FIR.
  always_ff @(posedge clk) begin
    if (cfg_wr_valid) begin
      bank_q[~active_q][cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    fir_en_d  = fir_en_q;
    reload_d  = reload_q;
    pending_d = pending_q;
    rerun_d   = rerun_q;
    idx_d     = idx_q;
    off_d     = off_q;
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
    sum_d = sum_q;
    chk_d = chk_q;
    if (tap_fire) begin
      sum_d = sum_q + SumW'(fir_tap_din);
    end
`endif

    outst_d = outst_q;
    if (m_fire && !d_fire && outst_q != 2'd3) begin
      outst_d = outst_q + 2'd1;
    end else if (!m_fire && d_fire && outst_q != 2'd0) begin
      outst_d = outst_q - 2'd1;
    end

    if (cfg_commit && !(state_q inside {StIdle, StRun})) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_commit) state_d = StDrain;
      end
      StRun: begin
        if (cfg_commit || rerun_q) begin
          state_d = StDrain;
          rerun_d = 1'b0;
        end
      end
      StDrain: begin
        if (outst_q == 2'd0) begin
          state_d  = StOff;
          active_d = ~active_q;
          fir_en_d = 1'b0;
          off_d    = '0;
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
          sum_d = '0;
`endif
        end
      end
      StOff: begin
        if (off_q == OffW'(G_OFF_CYCLES - 1)) begin
          state_d  = StLoad;
          fir_en_d = 1'b1;
          idx_d    = '0;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      StLoad: begin
        if (tap_fire) begin
          if (idx_q == IdxW'(G_NUM_TAPS - 1)) state_d = StWait;
          else                                idx_d   = idx_q + 1'b1;
        end
      end
      StWait: begin
        if (fir_tap_din_done) begin
          state_d   = StRun;
          reload_d  = reload_q + 8'd1;
          // A commit seen during the reload (or in this very cycle) triggers one more.
          rerun_d   = pending_q | cfg_commit;
          pending_d = 1'b0;
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
          chk_d = sum_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      active_q  <= 1'b0;
      fir_en_q  <= 1'b0;
      reload_q  <= '0;
      pending_q <= 1'b0;
      rerun_q   <= 1'b0;
      outst_q   <= '0;
      idx_q     <= '0;
      off_q     <= '0;
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
      sum_q <= '0;
      chk_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      fir_en_q  <= fir_en_d;
      reload_q  <= reload_d;
      pending_q <= pending_d;
      rerun_q   <= rerun_d;
      outst_q   <= outst_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
      sum_q <= sum_d;
      chk_q <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_fir_tap_load_ctrl.sv
// Bench for fir_tap_load_ctrl: a tap-stream/bank model plus FIR stub checks every load,
// and directed scenarios pin latency, draining, stalls, queued commits, reset abort and banking.
module tb_fir_tap_load_ctrl;
  localparam int N = 16;
  localparam int TW = 16;
  localparam int DW = 16;
  localparam int DONE_DLY = 2;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] cfg_wr_addr;
  logic [TW-1:0] cfg_wr_data;
  logic cfg_wr_valid, cfg_commit;
  logic busy, active_bank, fir_enable, fir_tap_din_valid, fir_tap_din_ready, fir_tap_din_done;
  logic [7:0] reload_count;
  logic [TW-1:0] fir_tap_din;
  logic [DW-1:0] s_din, m_din;
  logic s_din_valid, s_din_ready, m_din_valid, m_din_ready, fir_dout_valid, fir_dout_ready;
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
  logic [TW+3:0] tap_checksum;
`endif

  fir_tap_load_ctrl #(.G_NUM_TAPS(N), .G_TAP_WIDTH(TW), .G_DATA_WIDTH(DW), .G_OFF_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_valid(cfg_wr_valid),
    .cfg_commit(cfg_commit), .busy(busy), .active_bank(active_bank), .reload_count(reload_count),
    .fir_enable(fir_enable), .fir_tap_din(fir_tap_din), .fir_tap_din_valid(fir_tap_din_valid),
    .fir_tap_din_ready(fir_tap_din_ready), .fir_tap_din_done(fir_tap_din_done),
    .s_din(s_din), .s_din_valid(s_din_valid), .s_din_ready(s_din_ready),
    .m_din(m_din), .m_din_valid(m_din_valid), .m_din_ready(m_din_ready),
    .fir_dout_valid(fir_dout_valid), .fir_dout_ready(fir_dout_ready)
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
    , .tap_checksum(tap_checksum)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [TW-1:0] model_bank [2][N];
  logic [TW-1:0] exp_taps [N];
  logic [TW-1:0] prev_tap, tap3_seen;
  bit model_active, in_load, prev_valid, prev_stall, force_done;
  int k, exp_reloads, done_cnt, cyc, first_cyc, last_cyc;
  int ready_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor + FIR stub: checks at negedge, drives tap ready/done just after posedge.
  initial begin
    fir_tap_din_ready = 1'b1;
    fir_tap_din_done = 1'b0;
    done_cnt = 0; k = 0; cyc = 0; in_load = 0; prev_valid = 0; prev_stall = 0;
    model_active = 0; exp_reloads = 0; force_done = 0; tap3_seen = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_load = 0; k = 0; model_active = 0; exp_reloads = 0; done_cnt = 0;
        prev_valid = 0; prev_stall = 0;
      end else begin
        if (fir_tap_din_valid && !prev_valid) begin
          model_active = ~model_active;
          for (int i = 0; i < N; i++) exp_taps[i] = model_bank[model_active][i];
          in_load = 1; k = 0;
          check("load_active_bank", active_bank, model_active);
          check("load_reload_count", reload_count, exp_reloads[7:0]);
        end
        if (fir_tap_din_valid) begin
          check("load_fir_enable", fir_enable, 1);
          check("load_busy", busy, 1);
        end
        if (prev_stall && fir_tap_din_valid) check("tap_stable", fir_tap_din, prev_tap);
        if (fir_tap_din_valid && fir_tap_din_ready) begin
          if (k < N) begin
            check($sformatf("tap[%0d]", k), fir_tap_din, exp_taps[k]);
            if (k == 0) first_cyc = cyc;
            if (k == 3) tap3_seen = fir_tap_din;
            last_cyc = cyc;
          end else begin
            check("tap_overrun", k, N - 1);
          end
          k++;
          if (k == N) done_cnt = DONE_DLY;
        end
        if (!fir_tap_din_valid && prev_valid && in_load) begin
          check("load_length", k, N);
          in_load = 0;
        end
        if (busy) begin
          check("closed_m_din_valid", m_din_valid, 0);
          check("closed_s_din_ready", s_din_ready, 0);
        end
        if (m_din_valid) check("pass_m_din", m_din, s_din);
        prev_stall = fir_tap_din_valid && !fir_tap_din_ready;
        prev_tap = fir_tap_din;
        prev_valid = fir_tap_din_valid;
      end
      cyc++;
      @(posedge clk); #1;
      if (fir_tap_din_valid && ready_q.size() > 0) fir_tap_din_ready = ready_q.pop_front() != 0;
      else fir_tap_din_ready = 1'b1;
      if (done_cnt == 1) begin
        fir_tap_din_done = 1'b1;
        exp_reloads++;
      end else begin
        fir_tap_din_done = force_done;
      end
      if (done_cnt > 0) done_cnt--;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk); #1;
  endtask

  task automatic wr(input int addr, input int data);
    cfg_wr_addr = addr[3:0];
    cfg_wr_data = data[TW-1:0];
    cfg_wr_valid = 1'b1;
    model_bank[~model_active][addr] = data[TW-1:0];
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string name, output int n);
    n = 0;
    forever begin
      samp();
      if (busy === lvl) break;
      n++;
      if (n > 300) begin
        fails++; tests++;
        $display("FAIL %s: timeout waiting for busy=%0b", name, lvl);
        break;
      end
    end
  endtask

  task automatic wait_tap(input int idx, input string name);
    int t;
    t = 0;
    forever begin
      samp();
      if (in_load && k == idx) break;
      t++;
      if (t > 300) begin
        fails++; tests++;
        $display("FAIL %s: timeout waiting for tap %0d", name, idx);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_active_bank"}, active_bank, 0);
    check({tag, "_reload_count"}, reload_count, 0);
    check({tag, "_fir_enable"}, fir_enable, 0);
    check({tag, "_tap_valid"}, fir_tap_din_valid, 0);
    check({tag, "_tap_din"}, fir_tap_din, 0);
    check({tag, "_s_din_ready"}, s_din_ready, 0);
    check({tag, "_m_din_valid"}, m_din_valid, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cfg_wr_addr = '0; cfg_wr_data = '0; cfg_wr_valid = 1'b0; cfg_commit = 1'b0;
    s_din = 16'hAAAA; s_din_valid = 1'b1; m_din_ready = 1'b1;
    fir_dout_valid = 1'b0; fir_dout_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    samp();
    check_reset_outputs("rst");

    // Done outside WAIT is ignored
    tick(); force_done = 1'b1; tick(); tick(); force_done = 1'b0; tick();
    samp();
    check("idle_done_busy", busy, 1);
    check("idle_done_reload", reload_count, 0);
    tick(); s_din_valid = 1'b0;

    // 1: first load of bank1 with k+1
    for (int i = 0; i < N; i++) wr(i, i + 1);
    commit();
    wait_busy(0, "t1_load", n);
    check("t1_latency", n, 21);
    check("t1_active_bank", active_bank, 1);
    check("t1_reload_count", reload_count, 1);
    check("t1_model_reloads", reload_count, exp_reloads[7:0]);
    check("t1_consecutive", last_cyc - first_cyc, 15);
    check("t1_fir_enable", fir_enable, 1);
`ifdef FIR_TAP_LOAD_CHECKSUM_EN
    check("t1_checksum", tap_checksum, 136);
`endif
    for (int i = 0; i < N; i++) wr(i, 16'h0100 + i);

    // Data path open in RUN
    tick(); s_din = 16'h1234; s_din_valid = 1'b1; m_din_ready = 1'b0;
    samp();
    check("run_m_din_valid", m_din_valid, 1);
    check("run_m_din", m_din, 16'h1234);
    check("run_s_din_ready_lo", s_din_ready, 0);
    tick(); m_din_ready = 1'b1;
    samp();
    check("run_s_din_ready_hi", s_din_ready, 1);
    tick(); s_din_valid = 1'b0;

    // 2: commit with one sample in flight
    commit();
    samp();
    check("t2_s_din_ready", s_din_ready, 0);
    check("t2_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); samp();
      check($sformatf("t2_drain_en%0d", i), fir_enable, 1);
    end
    tick(); fir_dout_valid = 1'b1;
    samp(); check("t2_en_dout", fir_enable, 1);
    tick(); fir_dout_valid = 1'b0;
    samp(); check("t2_en_after", fir_enable, 1);
    tick(); samp(); check("t2_off0", fir_enable, 0);
    tick(); samp(); check("t2_off1", fir_enable, 0);
    tick(); samp(); check("t2_load_en", fir_enable, 1);
    check("t2_load_valid", fir_tap_din_valid, 1);
    wait_busy(0, "t2_load", n);
    check("t2_reload_count", reload_count, 2);
    check("t2_active_bank", active_bank, 0);

    // 3: ready stalls during load
    for (int i = 0; i < N; i++) wr(i, 16'h0200 + i);
    ready_q = '{1, 0, 0, 1};
    commit();
    wait_busy(0, "t3_load", n);
    check("t3_latency", n, 23);
    check("t3_span", last_cyc - first_cyc, 17);
    check("t3_reload_count", reload_count, 3);

    // 4: three commits during LOAD -> exactly one extra reload
    commit();
    wait_tap(2, "t4_load");
    for (int i = 0; i < 3; i++) begin
      tick(); cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
    end
    wait_busy(0, "t4_first", n);
    wait_busy(1, "t4_gap", n);
    check("t4_run_gap", n, 0);
    wait_busy(0, "t4_second", n);
    for (int i = 0; i < 5; i++) begin
      samp();
      check("t4_no_third", busy, 0);
    end
    check("t4_reload_count", reload_count, 5);
    check("t4_model_reloads", reload_count, exp_reloads[7:0]);

    // 5: reset at idx 7
    commit();
    wait_tap(7, "t5_load");
    tick(); reset = 1'b1; s_din_valid = 1'b1;
    tick(); reset = 1'b0;
    samp();
    check_reset_outputs("t5");
    tick(); s_din_valid = 1'b0;
    commit();
    wait_busy(0, "t5_reload", n);
    check("t5_latency", n, 21);
    check("t5_reload_count", reload_count, 1);
    check("t5_active_bank", active_bank, 1);

    // 6: write the inactive bank during a load
    commit();
    wait_busy(0, "t6_load0", n);
    commit();
    wait_tap(3, "t6_load1");
    wr(3, 16'h7FFF);
    wait_busy(0, "t6_load1_done", n);
    check("t6_current_tap3", tap3_seen, 16'h0203);
    commit();
    wait_busy(0, "t6_load0_again", n);
    check("t6_next_tap3", tap3_seen, 16'h7FFF);
    check("t6_reload_count", reload_count, 4);
    check("t6_active_bank", active_bank, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
